test: RTL and testbench

TEST -- requirements
Module: test

---
 rtl/test_pkg.sv | 19 +
 rtl/spi_master_shift.sv | 49 ++++
 rtl/test.sv | 144 ++++++++++++++
 tb/tb_test.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_pkg.sv
// rtl/test_pkg.sv - shared encodings and constants for the flash-to-SRAM boot copier
package test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam int         CMD_BITS       = 32;
    localparam int         WORD_BITS      = 16;
    localparam int         SRAM_WR_CYCLES = 4;
    localparam int         WR_CW          = $clog2(SRAM_WR_CYCLES);

endpackage

// File: rtl/spi_master_shift.sv
// rtl/spi_master_shift.sv - mode-0 SPI bit engine: clock divider, MSB-first shift out/in, bit strobe
module spi_master_shift #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] load_data,
    input  logic        miso,
    output logic        mosi,
    output logic        sck,
    output logic        bit_done,
    output logic [15:0] rx_data
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [31:0]   tx;

    // High on the edge that closes a bit: SCK falls and the next MOSI bit appears.
    assign bit_done = run && (cnt == CW'(CLK_DIV - 1));
    assign mosi     = tx[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sck     <= 1'b0;
            tx      <= '0;
            rx_data <= '0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
            tx  <= load_data;
        end else if (bit_done) begin
            cnt <= '0;
            sck <= 1'b0;
            tx  <= {tx[30:0], 1'b0};
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(HALF - 1)) begin
                sck     <= 1'b1;
                rx_data <= {rx_data[14:0], miso};
            end
        end
    end

endmodule

// File: rtl/test.sv
// rtl/test.sv - boot copier: streams an image from SPI flash into async SRAM and verifies its checksum
module test
    import test_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter int          BOOT_WORDS = 256,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [21:0] SRAM_BASE  = 22'h000000
) (
    input  logic        master_clk_i,
    input  logic        master_rst_i,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SS,
    output logic        SCK_SPI,
    output logic [21:0] sram_address_o,
    output logic [15:0] sram_datain_o,
    output logic [1:0]  sram_lb_ub_o,
    output logic        sram_cs_o,
    output logic        sram_oe_o,
    output logic        sram_we_o,
    output logic        sram_adv_o,
    output logic        sram_wait_o,
    output logic        sram_clk_o,
    output logic        bootstrap_initdone_o,
    output logic        error,
    output logic        reset,
    output logic        MISO1,
    output logic        MOSI1,
    output logic        SS1,
    output logic        SCK1
);

    localparam int IW = $clog2(BOOT_WORDS + 1);

    state_t            state;
    logic              run;
    logic              bit_done;
    logic              word_done;
    logic [4:0]        bit_cnt;
    logic [IW-1:0]     word_idx;
    logic [15:0]       sum;
    logic [WR_CW-1:0]  wr_cnt;
    logic [15:0]       rx_data;

    spi_master_shift #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk       (master_clk_i),
        .rst       (master_rst_i),
        .run       (run),
        .load_data ({CMD_READ, FLASH_BASE}),
        .miso      (MISO),
        .mosi      (MOSI),
        .sck       (SCK_SPI),
        .bit_done  (bit_done),
        .rx_data   (rx_data)
    );

    assign word_done = bit_done && ((state == CMD) ? (bit_cnt == 5'(CMD_BITS - 1))
                                                   : (bit_cnt == 5'(WORD_BITS - 1)));

    assign sram_oe_o   = 1'b1;
    assign sram_wait_o = 1'b0;
    assign sram_clk_o  = 1'b0;
    assign reset       = master_rst_i | ~bootstrap_initdone_o;
    assign MISO1       = MISO;
    assign MOSI1       = MOSI;
    assign SS1         = SS;
    assign SCK1        = SCK_SPI;

    always_ff @(posedge master_clk_i) begin
        if (master_rst_i) begin
            state                <= IDLE;
            run                  <= 1'b0;
            SS                   <= 1'b1;
            bit_cnt              <= '0;
            word_idx             <= '0;
            sum                  <= '0;
            wr_cnt               <= '0;
            sram_address_o       <= '0;
            sram_datain_o        <= '0;
            sram_lb_ub_o         <= 2'b11;
            sram_cs_o            <= 1'b1;
            sram_we_o            <= 1'b1;
            sram_adv_o           <= 1'b1;
            bootstrap_initdone_o <= 1'b0;
            error                <= 1'b0;
        end else begin
            // Bit counting runs independently of the SRAM write so the stream never stalls.
            if (bit_done) begin
                bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
            end
            case (state)
                IDLE: begin
                    SS    <= 1'b0;
                    run   <= 1'b1;
                    state <= CMD;
                end
                CMD: begin
                    if (word_done) state <= READ;
                end
                READ: begin
                    if (word_done) begin
                        sram_address_o <= SRAM_BASE + 22'(word_idx);
                        sram_datain_o  <= rx_data;
                        sram_cs_o      <= 1'b0;
                        sram_we_o      <= 1'b0;
                        sram_adv_o     <= 1'b0;
                        sram_lb_ub_o   <= 2'b00;
                        wr_cnt         <= '0;
                        sum            <= sum + rx_data;
                        word_idx       <= word_idx + 1'b1;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == WR_CW'(SRAM_WR_CYCLES - 2)) begin
                        sram_cs_o  <= 1'b1;
                        sram_we_o  <= 1'b1;
                        sram_adv_o <= 1'b1;
                    end
                    if (wr_cnt == WR_CW'(SRAM_WR_CYCLES - 1)) begin
                        sram_lb_ub_o <= 2'b11;
                        state        <= (word_idx == IW'(BOOT_WORDS)) ? CHECK : READ;
                    end
                end
                CHECK: begin
                    if (word_done) begin
                        SS                   <= 1'b1;
                        run                  <= 1'b0;
                        bootstrap_initdone_o <= 1'b1;
                        error                <= ((sum + rx_data) != 16'h0000);
                        state                <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test.sv
// tb/tb_test.sv - self-checking bench: flash and SRAM models, randomized images, protocol monitor
module tb_test;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso = 1'b0;
    logic        mosi, ss, sck;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  lb_ub;
    logic        cs, oe, we, adv, wt, sclk;
    logic        initdone, error, rst_out;
    logic        miso1, mosi1, ss1, sck1;

    int total = 0;
    int bad   = 0;

    test dut (
        .master_clk_i         (clk),
        .master_rst_i         (rst),
        .MISO                 (miso),
        .MOSI                 (mosi),
        .SS                   (ss),
        .SCK_SPI              (sck),
        .sram_address_o       (addr),
        .sram_datain_o        (din),
        .sram_lb_ub_o         (lb_ub),
        .sram_cs_o            (cs),
        .sram_oe_o            (oe),
        .sram_we_o            (we),
        .sram_adv_o           (adv),
        .sram_wait_o          (wt),
        .sram_clk_o           (sclk),
        .bootstrap_initdone_o (initdone),
        .error                (error),
        .reset                (rst_out),
        .MISO1                (miso1),
        .MOSI1                (mosi1),
        .SS1                  (ss1),
        .SCK1                 (sck1)
    );

    always #5 clk = ~clk;

    // Flash model: 32 command bits in, then image words MSB first, checksum last.
    logic [15:0] img [0:256];
    logic [31:0] cmd_cap;
    int          rise_cnt = 0;

    always @(posedge sck or negedge ss) begin
        if (sck === 1'b1 && ss === 1'b0) begin
            if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], mosi};
            rise_cnt++;
        end else if (ss === 1'b0) begin
            rise_cnt = 0;
            cmd_cap  = '0;
        end
    end

    always @(negedge sck) begin
        int k;
        if (ss === 1'b0 && rise_cnt >= 32) begin
            k = rise_cnt - 32;
            if (k / 16 <= 256) miso = img[k / 16][15 - (k % 16)];
            else miso = 1'b0;
        end
    end

    // Bus monitor: logs SRAM writes in order and counts protocol violations.
    logic [15:0] wdata [0:511];
    int wr_count = 0, cs_len = 0, viol = 0;
    int ss_len = 0, rises = 0, sck_run = 0, last_ss_len = 0, last_rises = 0;
    logic prev_sck = 1'b0, prev_ss = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            wr_count = 0; cs_len = 0; ss_len = 0; rises = 0; sck_run = 0;
        end else begin
            if (miso1 !== miso || mosi1 !== mosi || ss1 !== ss || sck1 !== sck) viol++;
            if (oe !== 1'b1 || wt !== 1'b0 || sclk !== 1'b0) viol++;
            if (rst_out !== ~initdone) viol++;
            if (cs === 1'b0) begin
                if (cs_len == 0) begin
                    if (addr !== 22'(wr_count)) viol++;
                    if (wr_count < 512) wdata[wr_count] = din;
                    wr_count++;
                end
                cs_len++;
                if (lb_ub !== 2'b00 || we !== 1'b0 || adv !== 1'b0) viol++;
            end else begin
                if (cs_len != 0 && cs_len != 3) viol++;
                cs_len = 0;
                if (we !== 1'b1 || adv !== 1'b1) viol++;
            end
            if (ss === 1'b0) begin
                ss_len++;
                if (sck === 1'b1 && prev_sck === 1'b0) rises++;
                if (sck !== prev_sck) begin
                    if (sck_run != 2) viol++;
                    sck_run = 1;
                end else begin
                    sck_run++;
                end
            end else begin
                if (prev_ss === 1'b0) begin
                    last_ss_len = ss_len;
                    last_rises  = rises;
                end
                ss_len = 0; rises = 0; sck_run = 0;
                if (sck !== 1'b0) viol++;
            end
        end
        prev_sck = sck;
        prev_ss  = ss;
    end

    task automatic set_rst(input logic v);
        @(posedge clk);
        #1 rst = v;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (initdone === 1'b1) break;
        end
    endtask

    task automatic start_run(input int mode);
        logic [15:0] s;
        set_rst(1'b1);
        repeat (3) @(posedge clk);
        s = 16'h0;
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       img[i] = 16'h0000;
                1:       img[i] = 16'(i);
                default: img[i] = 16'($urandom);
            endcase
            s = s + img[i];
        end
        case (mode)
            0:       img[256] = 16'h0000;
            1:       img[256] = 16'h8080;
            2:       img[256] = 16'h0000;
            default: img[256] = ($urandom_range(0, 1) == 1) ? 16'(-s) : 16'($urandom);
        endcase
        set_rst(1'b0);
    endtask

    function automatic logic exp_error();
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i <= 256; i++) s = s + img[i];
        return (s != 16'h0);
    endfunction

    function automatic int data_mismatches();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (wdata[i] !== img[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        set_rst(1'b1);
        repeat (3) @(negedge clk);
        total++;
        if ({ss, sck, mosi, cs, we, adv, oe, initdone, error, rst_out} !== 10'b1001111001) begin
            $display("FAIL reset_strobes got=%b want=%b",
                     {ss, sck, mosi, cs, we, adv, oe, initdone, error, rst_out}, 10'b1001111001);
            bad++;
        end
        total++;
        if ({addr, din, lb_ub} !== {22'h0, 16'h0, 2'b11}) begin
            $display("FAIL reset_bus got addr=%h data=%h lb_ub=%b want 0/0/11", addr, din, lb_ub);
            bad++;
        end
    endtask

    task automatic test_zero_image();
        int cyc, v0;
        v0 = viol;
        start_run(0);
        wait_done(cyc);
        @(negedge clk);
        total++;
        if (initdone !== 1'b1) begin
            $display("FAIL zero_done_timeout got=%b after %0d cycles want=1", initdone, cyc); bad++;
        end
        total++;
        if (cmd_cap !== 32'h03000000) begin
            $display("FAIL zero_cmd got=%h want=03000000", cmd_cap); bad++;
        end
        total++;
        if (wr_count !== 256) begin
            $display("FAIL zero_write_count got=%0d want=256", wr_count); bad++;
        end
        total++;
        if (data_mismatches() !== 0) begin
            $display("FAIL zero_data got=%0d bad words want=0", data_mismatches()); bad++;
        end
        total++;
        if (error !== 1'b0 || rst_out !== 1'b0) begin
            $display("FAIL zero_error_reset got err=%b reset=%b want 0/0", error, rst_out); bad++;
        end
        total++;
        if (last_ss_len !== 4144 * 4 || last_rises !== 4144) begin
            $display("FAIL zero_ss_window got cycles=%0d sck=%0d want %0d/4144",
                     last_ss_len, last_rises, 4144 * 4); bad++;
        end
        total++;
        if (viol - v0 !== 0) begin
            $display("FAIL zero_protocol got=%0d violations want=0", viol - v0); bad++;
        end
    endtask

    task automatic test_ramp(input logic corrupt);
        int cyc, v0;
        v0 = viol;
        start_run(corrupt ? 2 : 1);
        wait_done(cyc);
        total++;
        if (initdone !== 1'b1) begin
            $display("FAIL ramp_done got=%b want=1", initdone); bad++;
        end
        total++;
        if (wr_count !== 256 || data_mismatches() !== 0) begin
            $display("FAIL ramp_data got count=%0d bad=%0d want 256/0", wr_count, data_mismatches()); bad++;
        end
        total++;
        if (error !== corrupt) begin
            $display("FAIL ramp_error got=%b want=%b", error, corrupt); bad++;
        end
        repeat (50) @(negedge clk);
        total++;
        if (error !== corrupt || initdone !== 1'b1 || ss !== 1'b1) begin
            $display("FAIL ramp_sticky got err=%b done=%b ss=%b want %b/1/1", error, initdone, ss, corrupt); bad++;
        end
        total++;
        if (viol - v0 !== 0) begin
            $display("FAIL ramp_protocol got=%0d violations want=0", viol - v0); bad++;
        end
    endtask

    task automatic test_abort_random();
        int cyc, v0;
        logic want_err;
        v0 = viol;
        start_run(3);
        want_err = exp_error();
        repeat (5000) @(negedge clk);
        set_rst(1'b1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ss, sck, cs, initdone, rst_out} !== 5'b10101) begin
            $display("FAIL abort_state got ss,sck,cs,done,reset=%b want=10101",
                     {ss, sck, cs, initdone, rst_out}); bad++;
        end
        set_rst(1'b0);
        wait_done(cyc);
        total++;
        if (initdone !== 1'b1 || cmd_cap !== 32'h03000000) begin
            $display("FAIL abort_restart got done=%b cmd=%h want 1/03000000", initdone, cmd_cap); bad++;
        end
        total++;
        if (wr_count !== 256 || data_mismatches() !== 0) begin
            $display("FAIL abort_data got count=%0d bad=%0d want 256/0", wr_count, data_mismatches()); bad++;
        end
        total++;
        if (error !== want_err) begin
            $display("FAIL abort_error got=%b want=%b", error, want_err); bad++;
        end
        @(negedge clk);
        total++;
        if (last_ss_len !== 4144 * 4 || viol - v0 !== 0) begin
            $display("FAIL abort_protocol got ss=%0d viol=%0d want %0d/0", last_ss_len, viol - v0, 4144 * 4); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_image();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_abort_random();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
